fetch_unit: RTL

Instruction fetch stage that drives the 8-bit address of the combinational instruction memory. It holds the program counter and captures the returned 32-bit word into an instruction register for the decode stage. It supports a valid/ready handshake toward decode, redirects on taken branches/jumps, and halts on a configurable halt word.

---
 rtl/fetch_unit.sv | 91 +++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with PC, instruction register, decode handshake,
// branch redirect and halt-word detection. Rev 1.0
`default_nettype none

module fetch_unit #(
  parameter int                 ADDR_W    = 8,
  parameter int                 DATA_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [DATA_W-1:0]  HALT_INSN = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              dec_ready,
  output logic              halted
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic              valid_q;
  logic              halted_q;

  logic w_slot_free;
  logic w_is_halt;

  assign w_slot_free = !valid_q || dec_ready;
  assign w_is_halt   = (imem_data == HALT_INSN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          if (branch_taken) pc_q <= branch_target;
          state_q <= RUN;
        end
        RUN, HALT: begin
          if (branch_taken) begin
            // Redirect also flushes the wrong-path word even if decode accepts it now.
            pc_q     <= branch_target;
            valid_q  <= 1'b0;
            state_q  <= RUN;
            halted_q <= 1'b0;
          end else if (state_q == RUN && w_slot_free && !w_is_halt) begin
            instr_q    <= imem_data;
            instr_pc_q <= pc_q;
            valid_q    <= 1'b1;
            pc_q       <= pc_q + 1'b1;
          end else if (state_q == RUN && w_slot_free) begin
            // Halt word is never loaded; any pending word is consumed since the slot is free.
            state_q  <= HALT;
            halted_q <= 1'b1;
            valid_q  <= 1'b0;
          end else if (valid_q && dec_ready) begin
            valid_q <= 1'b0;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;

endmodule

`default_nettype wire
